seg7_scan_ctrl: RTL

Downstream display stage for the SoC: owns the Nexys A7 eight-digit seven-segment display and drives AN and {CA..CG} plus the decimal point.
- Software writes the digit values and masks through a small register port.
- The block time-multiplexes the eight digits in the clk_core domain.
- Blanking dead-time suppresses ghosting between digits.
- A double-buffered digit register gives tear-free frame updates.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_scan_ctrl_slot_timer.sv | 62 ++++++
 rtl/seg7_scan_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types, register map and hex decoder for the seven-segment scanner.
// SEG7_PWM_EN (optional) enables brightness gating of the lit window.
package seg7_pkg;

    localparam logic [1:0] ADDR_DIGITS = 2'd0;
    localparam logic [1:0] ADDR_ENABLE = 2'd1;
    localparam logic [1:0] ADDR_DP     = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    // Active-low segments, bit6=CA ... bit0=CG
    function automatic seg_t hex_decode(input nibble_t n);
        seg_t s;
        case (n)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_slot_timer.sv
// Slot/digit counters, frame wrap strobe and lit-window compare.
// SEG7_PWM_EN adds a brightness-scaled lit window.
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int CLK_DIV      = 12500,
    parameter int BLANK_CYCLES = 250
) (
    input  logic       clk,
    input  logic       rst,
`ifdef SEG7_PWM_EN
    input  logic [3:0] bright,
`endif
    output logic [2:0] index,
    output logic       lit,
    output logic       wrap
);

    localparam logic [15:0] LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] BLANK = 16'(BLANK_CYCLES);

    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        slot_end;

    // Next-state for the slot counter and digit index
    always_comb begin
        slot_end = (cnt_q == LAST);
        cnt_d    = slot_end ? 16'd0 : cnt_q + 16'd1;
        idx_d    = slot_end ? idx_q + 3'd1 : idx_q;
    end

    // Counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
            idx_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign index = idx_q;
    assign wrap  = slot_end && (idx_q == 3'd7);

`ifdef SEG7_PWM_EN
    localparam int SPAN  = (CLK_DIV - BLANK_CYCLES) / 16;
    localparam int SHIFT = (SPAN < 2) ? 0 : $clog2(SPAN + 1) - 1;

    logic [15:0] ofs;

    // Lit once blanking ends, until the brightness-scaled limit
    always_comb begin
        ofs = cnt_q - BLANK;
        lit = (cnt_q >= BLANK) && ((ofs >> SHIFT) <= {12'd0, bright});
    end
`else
    assign lit = (cnt_q >= BLANK);
`endif

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit seven-segment scan controller with double-buffered digits.
// SEG7_PWM_EN enables the brightness register at address 3.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int CLK_DIV      = 12500,
    parameter int BLANK_CYCLES = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_we,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_tick
);

    logic [31:0] shadow_q, shadow_d;
    logic [31:0] active_q, active_d;
    logic [7:0]  enable_q, enable_d;
    logic [7:0]  dp_q, dp_d;
    logic        pending_q, pending_d;
    logic [7:0]  an_n_q, an_n_d;
    seg_t        seg_n_q, seg_n_d;
    logic        dp_n_q, dp_n_d;
    logic        tick_q, tick_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  bright_rd;

    logic [2:0]  index;
    logic        lit;
    logic        wrap;
    logic        on;
    nibble_t     cur;

`ifdef SEG7_PWM_EN
    logic [3:0] bright_q, bright_d;
`endif

    seg7_slot_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
`ifdef SEG7_PWM_EN
        .bright (bright_q),
`endif
        .index  (index),
        .lit    (lit),
        .wrap   (wrap)
    );

`ifdef SEG7_PWM_EN
    assign bright_rd = bright_q;
`else
    assign bright_rd = 4'hF;
`endif

    // Register writes, frame commit and read mux
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        enable_d  = enable_q;
        dp_d      = dp_q;
        pending_d = pending_q;
`ifdef SEG7_PWM_EN
        bright_d  = bright_q;
`endif
        // Commit sees pre-write shadow; a same-cycle write re-arms pending
        if (wrap && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (reg_we) begin
            unique case (reg_addr)
                ADDR_DIGITS: begin
                    shadow_d  = reg_wdata;
                    pending_d = 1'b1;
                end
                ADDR_ENABLE: enable_d = reg_wdata[7:0];
                ADDR_DP:     dp_d     = reg_wdata[7:0];
                ADDR_STATUS: begin
`ifdef SEG7_PWM_EN
                    bright_d = reg_wdata[3:0];
`endif
                end
            endcase
        end
        unique case (reg_addr)
            ADDR_DIGITS: rdata_d = shadow_q;
            ADDR_ENABLE: rdata_d = {24'd0, enable_q};
            ADDR_DP:     rdata_d = {24'd0, dp_q};
            ADDR_STATUS: rdata_d = {23'd0, pending_q, index,
                                    bright_rd, 1'b0};
        endcase
    end

    // Display drive for the current slot
    always_comb begin
        cur      = active_q[{index, 2'b00} +: 4];
        on       = enable_q[index] && lit;
        an_n_d   = 8'hFF;
        if (on) an_n_d[index] = 1'b0;
        seg_n_d  = on ? hex_decode(cur) : 7'h7F;
        dp_n_d   = ~(dp_q[index] && on);
        tick_d   = wrap;
    end

    // Register and output state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= 32'd0;
            active_q  <= 32'd0;
            enable_q  <= 8'h00;
            dp_q      <= 8'h00;
            pending_q <= 1'b0;
            an_n_q    <= 8'hFF;
            seg_n_q   <= 7'h7F;
            dp_n_q    <= 1'b1;
            tick_q    <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            enable_q  <= enable_d;
            dp_q      <= dp_d;
            pending_q <= pending_d;
            an_n_q    <= an_n_d;
            seg_n_q   <= seg_n_d;
            dp_n_q    <= dp_n_d;
            tick_q    <= tick_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef SEG7_PWM_EN
    // Brightness register, full on after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bright_q <= 4'hF;
        else     bright_q <= bright_d;
    end
`endif

    assign an_n       = an_n_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign frame_tick = tick_q;
    assign reg_rdata  = rdata_q;

endmodule
